// File: rtl/delay_slot_arbiter_if.sv
// Bundle of signals between the requesting control FSMs and the shared
// delay-slot arbiter. The arbiter sits on the slave modport. The requester
// side, or a bench, sits on the master modport.
//
// Handshake: a requester raises req[i] and holds it for the whole slot.
// It owns the counter while gnt[i] is high. done[i] pulses for one cycle
// when the N-cycle count completes. The requester should drop req[i] after
// it sees done[i]. If it drops req[i] before done, the slot is aborted
// without a done pulse.
interface delay_slot_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int CBITS = 11
);
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  gnt;
    logic [NREQ-1:0]  done;
    logic             busy;
    logic [CBITS-1:0] cnt;
    logic             err;

    modport master (
        output req,
        input  gnt,
        input  done,
        input  busy,
        input  cnt,
        input  err
    );

    modport slave (
        input  req,
        output gnt,
        output done,
        output busy,
        output cnt,
        output err
    );
endinterface

// File: rtl/delay_slot_arbiter.sv
// Round-robin arbiter that lends one shared N-cycle delay counter to NREQ
// requesters. The flow is IDLE (arbitrate) -> COUNT (run 0..N) -> DONE
// (one-cycle done pulse) -> IDLE. There is always one IDLE cycle between
// grants. The round-robin pointer moves past the winner only when its slot
// ends, whether the slot completes or is aborted.
module delay_slot_arbiter #(
    parameter int NREQ  = 4,
    parameter int N     = 1250,
    parameter int CBITS = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    delay_slot_arbiter_if.slave  bus,
    output logic [1:0]           state_dbg
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW = PW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [CBITS-1:0] CNT_N    = CBITS'(N);
    localparam logic [CBITS-1:0] CNT_LAST = CBITS'(N - 1);
    localparam logic [PW-1:0]    W_LAST   = PW'(NREQ - 1);
    localparam logic [SW-1:0]    NREQ_W   = SW'(NREQ);
    localparam logic [NREQ-1:0]  ONE_HOT0 = NREQ'(1);

    logic [1:0]       state_q, state_d;
    logic [NREQ-1:0]  gnt_q,   gnt_d;
    logic [NREQ-1:0]  done_q,  done_d;
    logic [CBITS-1:0] cnt_q,   cnt_d;
    logic [PW-1:0]    ptr_q,   ptr_d;
    logic [PW-1:0]    w_q,     w_d;
    logic             err_q,   err_d;

    logic             req_any;
    logic             req_w;
    logic             win_found;
    logic [PW-1:0]    win_idx;
    logic [SW-1:0]    cand_sum;
    logic [PW-1:0]    cand_idx;
    logic [PW-1:0]    ptr_next;
    logic             gnt_bad;
    logic             cnt_bad;

    // Request summary, and whether the current owner still holds its request.
    always_comb begin
        req_any = |bus.req;
        req_w   = |(bus.req & (ONE_HOT0 << w_q));
    end

    // Round-robin search. Take the first set req bit from ptr upward, wrapping modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand_sum  = '0;
        cand_idx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_sum = {1'b0, ptr_q} + SW'(i);
            if (cand_sum >= NREQ_W) begin
                cand_sum = cand_sum - NREQ_W;
            end
            cand_idx = cand_sum[PW-1:0];
            if (!win_found && (|(bus.req & (ONE_HOT0 << cand_idx)))) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Pointer value that follows the current owner, wrapping after the last requester.
    always_comb begin
        if (w_q == W_LAST) begin
            ptr_next = '0;
        end else begin
            ptr_next = w_q + PW'(1);
        end
    end

    // Slot sequencing: arbitrate in IDLE, count in COUNT, pulse done in DONE.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        w_d     = w_q;
        case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    w_d     = win_idx;
                    gnt_d   = ONE_HOT0 << win_idx;
                    cnt_d   = '0;
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (!req_w) begin
                    // The owner gave up early. Release the counter with no done pulse.
                    gnt_d   = '0;
                    cnt_d   = '0;
                    ptr_d   = ptr_next;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = CNT_N;
                    done_d  = ONE_HOT0 << w_q;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CBITS'(1);
                end
            end
            S_DONE: begin
                // req is ignored here. This state always lasts exactly one cycle.
                gnt_d   = '0;
                cnt_d   = '0;
                ptr_d   = ptr_next;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Sticky fault detector. It watches the registered grant and counter for impossible values.
    always_comb begin
        gnt_bad = (gnt_q & (gnt_q - ONE_HOT0)) != '0;
        cnt_bad = cnt_q > CNT_N;
        err_d   = err_q | gnt_bad | cnt_bad;
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            w_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            w_q     <= w_d;
            err_q   <= err_d;
        end
    end

    // Output drive. busy is decoded directly from the registered state.
    always_comb begin
        bus.gnt   = gnt_q;
        bus.done  = done_q;
        bus.cnt   = cnt_q;
        bus.err   = err_q;
        bus.busy  = (state_q != S_IDLE);
        state_dbg = state_q;
    end

    // A done pulse always belongs to the current grant holder.
    a_done_matches_gnt: assert property (@(posedge clk) disable iff (rst)
        (done_q != '0) |-> (gnt_q == done_q));

    // A grant is held exactly while the slot is active.
    a_gnt_iff_active: assert property (@(posedge clk) disable iff (rst)
        (gnt_q != '0) == (state_q == S_COUNT || state_q == S_DONE));

    // Each grant yields at most one done pulse, so done never lasts two cycles.
    a_done_single: assert property (@(posedge clk) disable iff (rst)
        (done_q != '0) |=> (done_q == '0));
endmodule

// File: tb/tb_delay_slot_arbiter.sv
// Directed bench for delay_slot_arbiter. A table of per-cycle vectors drives
// an N=4 instance. Hand-written sequences cover asynchronous reset mid-count
// and an N=1 instance.
module tb_delay_slot_arbiter;
    logic clk;
    logic rst;
    logic [1:0] st4;
    logic [1:0] st1;

    int checks;
    int failures;

    delay_slot_arbiter_if #(.NREQ(4), .CBITS(4)) bus4 ();
    delay_slot_arbiter_if #(.NREQ(4), .CBITS(2)) bus1 ();

    delay_slot_arbiter #(.NREQ(4), .N(4), .CBITS(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus4),
        .state_dbg (st4)
    );

    delay_slot_arbiter #(.NREQ(4), .N(1), .CBITS(2)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus1),
        .state_dbg (st1)
    );

    // Clock block.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [3:0] done;
        logic [3:0] cnt;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] g,
                       input logic [3:0] d, input int c, input logic b);
        vec_t v;
        v.rst  = r;
        v.req  = rq;
        v.gnt  = g;
        v.done = d;
        v.cnt  = 4'(c);
        v.busy = b;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Applies req at the falling edge and waits just past the next rising edge.
    task automatic step4(input logic [3:0] rq);
        @(negedge clk);
        bus4.req = rq;
        @(posedge clk);
        #1;
    endtask

    task automatic expect4(input string tag, input logic [3:0] g, input logic [3:0] d,
                           input int c, input logic b);
        check({tag, " gnt"},  32'(bus4.gnt),  32'(g));
        check({tag, " done"}, 32'(bus4.done), 32'(d));
        check({tag, " cnt"},  32'(bus4.cnt),  32'(c));
        check({tag, " busy"}, 32'(bus4.busy), 32'(b));
    endtask

    initial begin
        logic [3:0] oh;
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        bus4.req  = '0;
        bus1.req  = '0;

        // A: single requester 0 from reset. cnt goes 0..4 and done comes on the 5th grant cycle.
        add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        for (int k = 0; k < 5; k++)
            add(0, 4'b0001, 4'b0001, (k == 4) ? 4'b0001 : 4'b0000, k, 1);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0);

        // B: all requesters held. Grants rotate 0,1,2,3,0 with one idle cycle between them.
        add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        for (int g = 0; g < 5; g++) begin
            oh = 4'b0001 << (g % 4);
            for (int k = 0; k < 5; k++)
                add(0, 4'b1111, oh, (k == 4) ? oh : 4'b0000, k, 1);
            add(0, 4'b1111, 4'b0000, 4'b0000, 0, 0);
        end

        // C: after a grant to requester 1, ptr=2. req=0011 must wrap to requester 0.
        add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        for (int k = 0; k < 5; k++)
            add(0, 4'b0010, 4'b0010, (k == 4) ? 4'b0010 : 4'b0000, k, 1);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b0011, 4'b0001, 4'b0000, 0, 1);
        add(0, 4'b0011, 4'b0001, 4'b0000, 1, 1);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b0011, 4'b0010, 4'b0000, 0, 1);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0);

        // D: requester 2 aborts at cnt=2. There is no done pulse, and ptr moves to 3.
        add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        for (int k = 0; k < 3; k++)
            add(0, 4'b0100, 4'b0100, 4'b0000, k, 1);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b1111, 4'b1000, 4'b0000, 0, 1);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst      = vecs[i].rst;
            bus4.req = vecs[i].req;
            @(posedge clk);
            #1;
            expect4($sformatf("row%0d", i), vecs[i].gnt, vecs[i].done,
                    int'(vecs[i].cnt), vecs[i].busy);
            check($sformatf("row%0d err", i), 32'(bus4.err), 32'd0);
        end

        // E: abort requester 1 so that ptr=2. Grant requester 2, then reset asynchronously at cnt=3.
        step4(4'b0010);
        expect4("e_grant1", 4'b0010, 4'b0000, 0, 1);
        step4(4'b0000);
        expect4("e_abort1", 4'b0000, 4'b0000, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step4(4'b0100);
            expect4($sformatf("e_cnt%0d", k), 4'b0100, 4'b0000, k, 1);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        expect4("e_async_rst", 4'b0000, 4'b0000, 0, 0);
        check("e_async_rst state", 32'(st4), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        bus4.req = 4'b0110;
        @(posedge clk);
        #1;
        expect4("e_after_rst", 4'b0010, 4'b0000, 0, 1);
        step4(4'b0000);
        expect4("e_final_idle", 4'b0000, 4'b0000, 0, 0);

        // F: with N=1, the grant lasts two cycles, cnt goes 0 then 1, and done comes in the second cycle.
        @(negedge clk);
        bus1.req = 4'b1000;
        @(posedge clk);
        #1;
        check("n1 c0 gnt",  32'(bus1.gnt),  32'(4'b1000));
        check("n1 c0 cnt",  32'(bus1.cnt),  32'd0);
        check("n1 c0 done", 32'(bus1.done), 32'd0);
        check("n1 c0 busy", 32'(bus1.busy), 32'd1);
        @(posedge clk);
        #1;
        check("n1 c1 gnt",  32'(bus1.gnt),  32'(4'b1000));
        check("n1 c1 cnt",  32'(bus1.cnt),  32'd1);
        check("n1 c1 done", 32'(bus1.done), 32'(4'b1000));
        @(negedge clk);
        bus1.req = 4'b0000;
        @(posedge clk);
        #1;
        check("n1 c2 gnt",  32'(bus1.gnt),  32'd0);
        check("n1 c2 done", 32'(bus1.done), 32'd0);
        check("n1 c2 busy", 32'(bus1.busy), 32'd0);
        check("n1 err",     32'(bus1.err),  32'd0);
        check("n4 err",     32'(bus4.err),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/delay_slot_arbiter.md
Name: delay_slot_arbiter

Overview:
- Shares one delay counter among NREQ requesters.
- Each requester holds its req line to ask for an N-cycle delay slot.
- The arbiter picks a requester round-robin, grants it the counter, and runs the count to N. It then pulses that requester's done bit and moves on.
- Sits between the control FSMs that need timed waits and the single shared delay counter, so each waiter does not need its own counter.

Parameters:
- NREQ, 4, number of requesters (at least 2).
- N, 1250, delay length in clock cycles (at least 1).
- CBITS, 11, counter width; N < 2^CBITS is required.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  NREQ  per-requester delay request, level-held.
- gnt  output  NREQ  one-hot grant, registered.
- done  output  NREQ  one-hot, one-cycle completion pulse.
- busy  output  1  high whenever state is not IDLE.
- cnt  output  CBITS  current shared counter value.
- err  output  1  sticky fault flag.

Behaviour:
- Reset (asynchronous, while rst is high):
  - state = IDLE, gnt = 0, done = 0, cnt = 0, err = 0.
  - Round-robin pointer ptr = 0.
- States: IDLE, COUNT, DONE. busy = (state != IDLE).
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise the winner w is the first set req bit searching from ptr upward, wrapping modulo NREQ.
  - Next edge: gnt <= onehot(w), cnt <= 0, state <= COUNT.
- COUNT:
  - If req[w] == 0, abort. Next edge: gnt <= 0, cnt <= 0, ptr <= (w+1) mod NREQ, state <= IDLE. No done pulse.
  - Else if cnt == N-1: next edge cnt <= N, done <= onehot(w), state <= DONE.
  - Else cnt <= cnt + 1.
- DONE (exactly one cycle):
  - Next edge: done <= 0, gnt <= 0, cnt <= 0, ptr <= (w+1) mod NREQ, state <= IDLE.
  - req is ignored in this state.
  - The requester must drop req after it sees done, otherwise it is re-arbitrated normally.
- Latency:
  - req sampled at IDLE edge e0, gnt high from e0 to e0+N+1, so N+1 cycles.
  - done high for the single cycle between e0+N and e0+N+1.
  - The next grant can start no earlier than edge e0+N+2, because one IDLE cycle always separates grants.
- Arithmetic: cnt is unsigned CBITS wide and never wraps. cnt stays within [0, N] by construction.
- err: set on any edge where cnt > N or gnt is not one-hot-or-zero. It stays set until rst. Fault-free operation keeps err = 0.
- Invariants:
  - done implies gnt equals done.
  - gnt != 0 iff state is COUNT or DONE.
  - At most one done pulse per grant.
- Simultaneous requests: only the winner is granted. The others wait, and round-robin guarantees each waiter a grant within NREQ-1 slots.
- Reset mid-operation: everything returns to reset values immediately, asynchronously. No done pulse is produced for the interrupted grant.

Test Plan:
- N=4, NREQ=4, req=0001 held from cycle 0 until done:
  - gnt=0001 from edge 1 to edge 6.
  - cnt goes 0,1,2,3,4.
  - done=0001 for exactly one cycle (edge 5 to 6).
  - err=0.
- N=4, req=1111 held continuously:
  - grants in order 0001, 0010, 0100, 1000, 0001.
  - each grant lasts 5 cycles with one IDLE cycle between grants.
  - one done pulse per grant.
- N=4, ptr=2 after a grant to requester 1, then req=0011:
  - winner is requester 0, found by wrapping past bits 2 and 3.
- N=4, req=0100 granted, then req[2] dropped while cnt=2:
  - gnt becomes 0 on the next edge and no done pulse occurs.
  - ptr becomes 3, and busy drops.
- N=4, rst asserted asynchronously while cnt=3 in COUNT:
  - gnt, done, cnt and busy go to 0 immediately without waiting for a clock edge.
  - after rst releases, req=0010 is granted from ptr=0 (requester 1 wins).
- N=1:
  - req=1000 gives gnt for 2 cycles, with cnt going 0 then 1.
  - done is asserted in the second cycle.
